// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_wr_arb_pkg;

  // Widest requester vector the one-hot helper can produce.
  localparam int unsigned MaxReqs = 32;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // One-hot vector with bit idx set; callers truncate to their own width.
  function automatic logic [MaxReqs-1:0] onehot(input int unsigned idx);
    logic [MaxReqs-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
module arb_rr_pick #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0]  i_req,
  input  logic [IDX_WIDTH-1:0] i_ptr,
  output logic                 o_vld,
  output logic [IDX_WIDTH-1:0] o_idx
);

  logic [2*NUM_REQS-1:0] req_dbl;

  // Scan the doubled vector from ptr; downward loop so the lowest offset wins.
  always_comb begin
    req_dbl = {i_req, i_req};
    o_vld   = |i_req;
    o_idx   = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (req_dbl[int'(i_ptr) + i]) begin
        o_idx = IDX_WIDTH'((int'(i_ptr) + i) % int'(NUM_REQS));
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQS requesters,
// granting bounded bursts of up to MAX_BURST accepted beats.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQS),
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQS-1:0]            i_req,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQS-1:0]            o_gnt,
  output logic                           o_busy,
  output logic [IDX_WIDTH-1:0]           o_owner,
  input  logic                           i_fifo_full,
  output logic                           o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]          o_fifo_wr_data
);

  arb_state_t           state_q;
  logic [NUM_REQS-1:0]  gnt_q;
  logic [IDX_WIDTH-1:0] owner_q;
  logic [IDX_WIDTH-1:0] ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 pick_vld;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 own_req;
  logic                 wr_en;
  logic                 last_beat;
  logic [IDX_WIDTH-1:0] ptr_next;

  arb_rr_pick #(
    .NUM_REQS  (NUM_REQS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_vld (pick_vld),
    .o_idx (pick_idx)
  );

  // Write path: owner's slice passes through only while a burst is active.
  always_comb begin
    own_req        = i_req[owner_q];
    wr_en          = 1'b0;
    o_fifo_wr_data = '0;
    if (state_q == ARB_BURST) begin
      o_fifo_wr_data = i_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
      wr_en          = own_req && !i_fifo_full;
    end
    last_beat = wr_en && (cnt_q == CNT_WIDTH'(MAX_BURST - 1));
    ptr_next  = (owner_q == IDX_WIDTH'(NUM_REQS - 1)) ? '0 : owner_q + IDX_WIDTH'(1);
  end

  // Arbiter FSM: grant in IDLE, count accepted beats in BURST, rotate on exit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_vld) begin
            state_q <= ARB_BURST;
            owner_q <= pick_idx;
            gnt_q   <= NUM_REQS'(onehot(32'(pick_idx)));
            cnt_q   <= '0;
          end
        end
        ARB_BURST: begin
          // Dropped request ends the burst even while the FIFO is full.
          if (!own_req || last_beat) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= ptr_next;
            cnt_q   <= '0;
          end else if (wr_en) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign o_gnt        = gnt_q;
  assign o_busy       = (state_q == ARB_BURST);
  assign o_owner      = owner_q;
  assign o_fifo_wr_en = wr_en;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomised bench for fifo_wr_arb against a burst-level reference model.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic            full;
  logic [N-1:0]    gnt;
  logic            busy;
  logic [1:0]      owner;
  logic            wr_en;
  logic [DW-1:0]   wr_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the port, how many beats it has had, who is next.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_beats = 0;
  int m_prio  = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NUM_REQS   (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .IDX_WIDTH  (2),
    .CNT_WIDTH  (3)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_data         (data),
    .o_gnt          (gnt),
    .o_busy         (busy),
    .o_owner        (owner),
    .i_fifo_full    (full),
    .o_fifo_wr_en   (wr_en),
    .o_fifo_wr_data (wr_data)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void release_port();
    m_busy  = 1'b0;
    m_prio  = (m_owner + 1) % N;
    m_owner = 0;
    m_beats = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_edge();
    if (rst) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_beats = 0;
      m_prio  = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (req[(m_prio + k) % N]) m_owner = (m_prio + k) % N;
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      release_port();
    end else if (!full) begin
      m_beats++;
      if (m_beats == MB) release_port();
    end
  endfunction

  task automatic compare_outputs();
    logic [N-1:0]  e_gnt;
    logic          e_wr;
    logic [DW-1:0] e_data;
    e_gnt  = '0;
    e_wr   = 1'b0;
    e_data = '0;
    if (m_busy) begin
      e_gnt[m_owner] = 1'b1;
      e_wr           = req[m_owner] && !full;
      e_data         = data[m_owner*DW +: DW];
    end
    check_val("gnt", 64'(gnt), 64'(e_gnt));
    check_val("busy", 64'(busy), 64'(m_busy));
    check_val("owner", 64'(owner), 64'(m_owner));
    check_val("wr_en", 64'(wr_en), 64'(e_wr));
    check_val("wr_data", 64'(wr_data), 64'(e_data));
  endtask

  task automatic step(input logic n_rst, input logic [N-1:0] n_req, input logic n_full);
    @(posedge clk);
    model_edge();
    #1;
    rst  = n_rst;
    req  = n_req;
    full = n_full;
    for (int k = 0; k < N; k++) data[k*DW +: DW] = $urandom;
    #1;
    compare_outputs();
  endtask

  int       wr_count;
  logic [N-1:0] r_req;
  logic         r_full;
  logic         r_rst;

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    full = 1'b0;
    data = '0;

    // Reset held with all requests up: nothing may be granted.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);

    // Continuous requests: four bursts of four beats, one idle gap each.
    wr_count = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b1111, 1'b0);
      if (wr_en) wr_count++;
    end
    check_val("writes_in_20", 64'(wr_count), 64'd16);

    // Random traffic with occasional full stalls, request drops and resets.
    r_req = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r_req = 4'($urandom);
      r_full = ($urandom_range(0, 3) == 0);
      r_rst  = ($urandom_range(0, 99) == 0);
      step(r_rst, r_req, r_full);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
